// File: rtl/shift_pkg.sv
// Shared types for the shifter-operand sequencer.
//   sh_type_e : ARM shift type encodings as carried on req_type
//   state_e   : sequencer FSM states
//   dec_cls_e : amount-decode classes produced by shift_amt_decode
//   ctx_t     : request context latched at accept time
package shift_pkg;

    localparam int unsigned AMT_W  = 8;   // register-amount bits used (Rs[7:0])
    localparam int unsigned CORE_W = 5;   // amount for the 1..31 barrel path

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_type_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RS_REQ  = 3'd1,
        RS_WAIT = 3'd2,
        EXEC    = 3'd3,
        RESP    = 3'd4
    } state_e;

    // PASS    : result = op_m, C = carry_in
    // CORE    : barrel shift by 1..31
    // ZERO_C0 : result 0, C = 0
    // ZERO_CB : result 0, C = boundary bit (op_m[0] for LSL, op_m[31] for LSR)
    // FILL    : result = sign fill, C = op_m[31]
    // RRX     : rotate right through carry by one
    // ROR32   : result = op_m, C = op_m[31]
    typedef enum logic [2:0] {
        PASS    = 3'd0,
        CORE    = 3'd1,
        ZERO_C0 = 3'd2,
        ZERO_CB = 3'd3,
        FILL    = 3'd4,
        RRX     = 3'd5,
        ROR32   = 3'd6
    } dec_cls_e;

    typedef struct packed {
        logic             imm;
        sh_type_e         sh_type;
        logic [AMT_W-1:0] amt;
        logic             carry_in;
    } ctx_t;

endpackage

// File: rtl/shift_amt_decode.sv
// Combinational decode of an ARM shift amount into a result class.
//   imm        : 1 = amount came from imm5 (only amt[4:0] meaningful)
//   sh_type    : shift type
//   amt        : 8-bit amount (imm5 zero-extended, or Rs[7:0])
//   cls_c      : decode class
//   core_amt_c : shift distance for the CORE class (1..31)
module shift_amt_decode
    import shift_pkg::*;
(
    input  logic              imm,
    input  sh_type_e          sh_type,
    input  logic [AMT_W-1:0]  amt,
    output dec_cls_e          cls_c,
    output logic [CORE_W-1:0] core_amt_c
);

    logic [CORE_W-1:0] amt_lo;
    logic              amt_lt32;
    logic              amt_eq32;
    logic              amt_zero;

    assign amt_lo   = amt[CORE_W-1:0];
    assign amt_lt32 = (amt[AMT_W-1:CORE_W] == '0);
    assign amt_eq32 = (amt == AMT_W'(32));
    assign amt_zero = (amt == '0);

    // Immediate #0 carries the special encodings; register amounts decode
    // the >=32 boundaries, with Rs[7:0]==0 always passing through.
    always_comb begin
        cls_c      = CORE;
        core_amt_c = amt_lo;
        if (imm) begin
            if (amt_lo == '0) begin
                case (sh_type)
                    SH_LSL: cls_c = PASS;
                    SH_LSR: cls_c = ZERO_CB;
                    SH_ASR: cls_c = FILL;
                    SH_ROR: cls_c = RRX;
                endcase
            end
        end else if (amt_zero) begin
            cls_c = PASS;
        end else begin
            case (sh_type)
                SH_LSL, SH_LSR: begin
                    if (amt_eq32) begin
                        cls_c = ZERO_CB;
                    end else if (!amt_lt32) begin
                        cls_c = ZERO_C0;
                    end
                end
                SH_ASR: begin
                    if (!amt_lt32) begin
                        cls_c = FILL;
                    end
                end
                SH_ROR: begin
                    // Multiples of 32 leave the value intact but still set C.
                    if (amt_lo == '0) begin
                        cls_c = ROR32;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_seq.sv
// Sequencer for the ARM shifter-operand path. Accepts one shift request,
// fetches Rs over a shared read port when the amount is register-sourced,
// and presents the shifted operand and carry-out under valid/ready.
//   clk, rst          : clock, asynchronous active-high reset
//   req_*             : request handshake and payload (type, amount, op_m, C)
//   rs_rd_*           : register-file read port (req/idx out, gnt/data in)
//   res_*             : result handshake, shifted operand and carry-out
//   busy              : sequencer not idle
module shift_seq
    import shift_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned RIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_imm,
    input  logic [1:0]        req_type,
    input  logic [4:0]        req_imm_amt,
    input  logic [RIDX_W-1:0] req_rs_idx,
    input  logic [DW-1:0]     req_op_m,
    input  logic              req_carry_in,
    output logic              rs_rd_req,
    output logic [RIDX_W-1:0] rs_rd_idx,
    input  logic              rs_rd_gnt,
    input  logic [DW-1:0]     rs_rd_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     res_result,
    output logic              res_carry,
    output logic              busy
);

    state_e            state_q, state_d;
    ctx_t              ctx_q, ctx_d;
    logic [DW-1:0]     op_m_q, op_m_d;
    logic              rs_rd_req_q, rs_rd_req_d;
    logic [RIDX_W-1:0] rs_rd_idx_q, rs_rd_idx_d;
    logic              res_valid_q, res_valid_d;
    logic [DW-1:0]     res_result_q, res_result_d;
    logic              res_carry_q, res_carry_d;
    logic              busy_q, busy_d;

    dec_cls_e          dec_cls_c;
    logic [CORE_W-1:0] core_amt_c;
    logic [DW:0]       lsl_ext_c;
    logic [DW:0]       lsr_ext_c;
    logic [DW:0]       asr_ext_c;
    logic [DW-1:0]     ror_res_c;
    logic [DW-1:0]     core_res_c;
    logic              core_carry_c;
    logic [DW-1:0]     shift_res_c;
    logic              shift_carry_c;

    // Only Rs[7:0] selects the amount; the upper bits are architecturally ignored.
    logic unused_rs_hi;
    assign unused_rs_hi = ^rs_rd_data[DW-1:AMT_W];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_imm ? EXEC : RS_REQ;
            RS_REQ:  if (rs_rd_gnt) state_d = RS_WAIT;
            RS_WAIT: state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and context next-values
    always_comb begin
        ctx_d        = ctx_q;
        op_m_d       = op_m_q;
        res_valid_d  = res_valid_q;
        res_result_d = res_result_q;
        res_carry_d  = res_carry_q;
        rs_rd_req_d  = (state_d == RS_REQ);
        busy_d       = (state_d != IDLE);
        rs_rd_idx_d  = '0;

        // Index is captured on accept and held for the whole RS_REQ stall.
        if (state_d == RS_REQ) begin
            rs_rd_idx_d = (state_q == IDLE) ? req_rs_idx : rs_rd_idx_q;
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ctx_d.imm      = req_imm;
                    ctx_d.sh_type  = sh_type_e'(req_type);
                    ctx_d.amt      = req_imm ? AMT_W'(req_imm_amt) : '0;
                    ctx_d.carry_in = req_carry_in;
                    op_m_d         = req_op_m;
                end
            end
            RS_WAIT: begin
                ctx_d.amt = rs_rd_data[AMT_W-1:0];
            end
            EXEC: begin
                res_valid_d  = 1'b1;
                res_result_d = shift_res_c;
                res_carry_d  = shift_carry_c;
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output and context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctx_q        <= '0;
            op_m_q       <= '0;
            rs_rd_req_q  <= 1'b0;
            rs_rd_idx_q  <= '0;
            res_valid_q  <= 1'b0;
            res_result_q <= '0;
            res_carry_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ctx_q        <= ctx_d;
            op_m_q       <= op_m_d;
            rs_rd_req_q  <= rs_rd_req_d;
            rs_rd_idx_q  <= rs_rd_idx_d;
            res_valid_q  <= res_valid_d;
            res_result_q <= res_result_d;
            res_carry_q  <= res_carry_d;
            busy_q       <= busy_d;
        end
    end

    shift_amt_decode u_decode (
        .imm        (ctx_q.imm),
        .sh_type    (ctx_q.sh_type),
        .amt        (ctx_q.amt),
        .cls_c      (dec_cls_c),
        .core_amt_c (core_amt_c)
    );

    // Barrel paths for n = 1..31. One extra bit on each shift catches the
    // last bit shifted out, which is the ARM carry-out.
    always_comb begin
        lsl_ext_c = {1'b0, op_m_q} << core_amt_c;
        lsr_ext_c = {op_m_q, 1'b0} >> core_amt_c;
        asr_ext_c = $signed({op_m_q, 1'b0}) >>> core_amt_c;
        ror_res_c = DW'({op_m_q, op_m_q} >> core_amt_c);

        core_res_c   = '0;
        core_carry_c = 1'b0;
        case (ctx_q.sh_type)
            SH_LSL: {core_carry_c, core_res_c} = lsl_ext_c;
            SH_LSR: {core_res_c, core_carry_c} = lsr_ext_c;
            SH_ASR: {core_res_c, core_carry_c} = asr_ext_c;
            SH_ROR: begin
                core_res_c   = ror_res_c;
                core_carry_c = ror_res_c[DW-1];
            end
        endcase
    end

    // Class mux selecting the final operand and carry.
    always_comb begin
        shift_res_c   = op_m_q;
        shift_carry_c = ctx_q.carry_in;
        case (dec_cls_c)
            PASS: begin
                shift_res_c   = op_m_q;
                shift_carry_c = ctx_q.carry_in;
            end
            CORE: begin
                shift_res_c   = core_res_c;
                shift_carry_c = core_carry_c;
            end
            ZERO_C0: begin
                shift_res_c   = '0;
                shift_carry_c = 1'b0;
            end
            ZERO_CB: begin
                shift_res_c   = '0;
                shift_carry_c = (ctx_q.sh_type == SH_LSL) ? op_m_q[0] : op_m_q[DW-1];
            end
            FILL: begin
                shift_res_c   = {DW{op_m_q[DW-1]}};
                shift_carry_c = op_m_q[DW-1];
            end
            RRX: begin
                shift_res_c   = {ctx_q.carry_in, op_m_q[DW-1:1]};
                shift_carry_c = op_m_q[0];
            end
            ROR32: begin
                shift_res_c   = op_m_q;
                shift_carry_c = op_m_q[DW-1];
            end
            default: ;
        endcase
    end

    // Ready is a pure function of state, held low while reset is applied.
    assign req_ready  = (state_q == IDLE) && !rst;
    assign rs_rd_req  = rs_rd_req_q;
    assign rs_rd_idx  = rs_rd_idx_q;
    assign res_valid  = res_valid_q;
    assign res_result = res_result_q;
    assign res_carry  = res_carry_q;
    assign busy       = busy_q;

endmodule
